// File: rtl/axi_lite_dram_slave.sv
// AXI4-Lite slave standing in for the off-chip DRAM behind the bridge.
// Word-addressed register-array memory with independent read and write
// paths, one outstanding transaction each, and fixed response latencies.
module axi_lite_dram_slave #(
    parameter int                 ADDR_W = 17,
    parameter int                 DATA_W = 64,
    parameter logic [ADDR_W-1:0]  BASE   = 17'h10000,
    parameter int                 DEPTH  = 256,
    parameter int                 RD_LAT = 4,
    parameter int                 WR_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              awvalid,
    output logic              awready,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wvalid,
    output logic              wready,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    input  logic [ADDR_W-1:0] araddr,
    input  logic              arvalid,
    output logic              arready,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rvalid,
    input  logic              rready
);

    localparam int WB_LOG = $clog2(DATA_W / 8);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int WC_W   = $clog2(WR_LAT + 1);
    localparam int RC_W   = $clog2(RD_LAT + 1);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_t;

    // Out of range below/above the window, or not word aligned.
    function automatic logic addr_err(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        logic [ADDR_W-1:0] word;
        off  = a - BASE;
        word = off >> WB_LOG;
        return (a < BASE) || (word >= ADDR_W'(DEPTH)) || (off[WB_LOG-1:0] != '0);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] word;
        word = (a - BASE) >> WB_LOG;
        return word[IDX_W-1:0];
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    wstate_t           wst_q, wst_d;
    logic              aw_got_q, aw_got_d;
    logic              w_got_q, w_got_d;
    logic              awready_q, awready_d;
    logic              wready_q, wready_d;
    logic [WC_W-1:0]   wcnt_q, wcnt_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              mem_we;

    rstate_t           rst_st_q, rst_st_d;
    logic              arready_q, arready_d;
    logic [RC_W-1:0]   rcnt_q, rcnt_d;
    logic              rvalid_q, rvalid_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;

    // Write path: collect AW and W in any order, wait WR_LAT, commit, respond.
    always_comb begin
        wst_d     = wst_q;
        aw_got_d  = aw_got_q;
        w_got_d   = w_got_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        wcnt_d    = wcnt_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        mem_we    = 1'b0;
        case (wst_q)
            W_IDLE: begin
                if (awvalid && awready_q) begin
                    aw_got_d = 1'b1;
                    awaddr_d = awaddr;
                end
                if (wvalid && wready_q) begin
                    w_got_d = 1'b1;
                    wdata_d = wdata;
                end
                // Readys come up on the first edge after reset and drop after capture.
                awready_d = !aw_got_d;
                wready_d  = !w_got_d;
                if (aw_got_d && w_got_d) begin
                    wst_d     = W_WAIT;
                    wcnt_d    = WC_W'(WR_LAT - 1);
                    aw_got_d  = 1'b0;
                    w_got_d   = 1'b0;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                end
            end
            W_WAIT: begin
                if (wcnt_q == '0) begin
                    mem_we   = !addr_err(awaddr_q);
                    bresp_d  = addr_err(awaddr_q) ? RESP_SLVERR : RESP_OKAY;
                    bvalid_d = 1'b1;
                    wst_d    = W_RESP;
                end else begin
                    wcnt_d = wcnt_q - 1'b1;
                end
            end
            W_RESP: begin
                if (bready) begin
                    bvalid_d  = 1'b0;
                    bresp_d   = RESP_OKAY;
                    wst_d     = W_IDLE;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                end
            end
            default: wst_d = W_IDLE;
        endcase
    end

    // Read path: accept AR, wait RD_LAT, sample memory, hold until taken.
    always_comb begin
        rst_st_d  = rst_st_q;
        arready_d = arready_q;
        rcnt_d    = rcnt_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        araddr_d  = araddr_q;
        case (rst_st_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (arvalid && arready_q) begin
                    araddr_d  = araddr;
                    arready_d = 1'b0;
                    rcnt_d    = RC_W'(RD_LAT - 1);
                    rst_st_d  = R_WAIT;
                end
            end
            R_WAIT: begin
                if (rcnt_q == '0) begin
                    // Sampled before this edge's write commit lands: same-edge reads see old data.
                    rdata_d  = addr_err(araddr_q) ? '0 : mem[addr_idx(araddr_q)];
                    rresp_d  = addr_err(araddr_q) ? RESP_SLVERR : RESP_OKAY;
                    rvalid_d = 1'b1;
                    rst_st_d = R_DATA;
                end else begin
                    rcnt_d = rcnt_q - 1'b1;
                end
            end
            R_DATA: begin
                if (rready) begin
                    rvalid_d  = 1'b0;
                    rdata_d   = '0;
                    rresp_d   = RESP_OKAY;
                    arready_d = 1'b1;
                    rst_st_d  = R_IDLE;
                end
            end
            default: rst_st_d = R_IDLE;
        endcase
    end

    // Control and output registers; reset aborts both paths immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wst_q     <= W_IDLE;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            wcnt_q    <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rst_st_q  <= R_IDLE;
            arready_q <= 1'b0;
            rcnt_q    <= '0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            wst_q     <= wst_d;
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            wcnt_q    <= wcnt_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rst_st_q  <= rst_st_d;
            arready_q <= arready_d;
            rcnt_q    <= rcnt_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    // Captured address/data need no reset; they are only used once the matching flag is set.
    always_ff @(posedge clk) begin
        awaddr_q <= awaddr_d;
        wdata_q  <= wdata_d;
        araddr_q <= araddr_d;
    end

    // Memory array is intentionally left uninitialised.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_idx(awaddr_q)] <= wdata_q;
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rresp   = rresp_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_axi_lite_dram_slave.sv
// Self-checking bench for axi_lite_dram_slave: transaction-level model with
// per-cycle output comparison, plus directed scenarios with literal expectations.
module tb_axi_lite_dram_slave;

    localparam int ADDR_W = 17;
    localparam int DATA_W = 64;
    localparam int DEPTH  = 256;
    localparam int RD_LAT = 4;
    localparam int WR_LAT = 4;
    localparam int BASE_I = 'h10000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] awaddr = '0;
    logic              awvalid = 1'b0;
    logic              awready;
    logic [DATA_W-1:0] wdata = '0;
    logic              wvalid = 1'b0;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready = 1'b1;
    logic [ADDR_W-1:0] araddr = '0;
    logic              arvalid = 1'b0;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    axi_lite_dram_slave #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE(17'h10000),
        .DEPTH(DEPTH), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    function automatic bit m_err(input logic [ADDR_W-1:0] a);
        int ai;
        ai = int'(a);
        return (ai < BASE_I) || (ai >= BASE_I + DEPTH * 8) || (ai % 8 != 0);
    endfunction

    function automatic int m_idx(input logic [ADDR_W-1:0] a);
        return (int'(a) - BASE_I) / 8;
    endfunction

    logic [63:0] mm [int];
    bit          armed = 0;
    bit          rd_out = 0, rd_smp = 0;
    int          rd_hs = 0;
    logic [ADDR_W-1:0] rd_a;
    logic [63:0] rd_d;
    logic [1:0]  rd_r;
    bit          aw_have = 0, w_have = 0, wr_busy = 0, wr_cm = 0;
    int          wr_done = 0;
    logic [ADDR_W-1:0] wa;
    logic [63:0] wd;
    logic [1:0]  wr_r;
    int          n_edge = 0;

    // Compare outputs to the model each cycle, then advance the model to the next edge.
    always @(negedge clk) begin : model
        bit e_awr, e_wr, e_bv, e_arr, e_rv;
        logic [63:0] e_rdata;
        if (rst) begin
            armed = 0; rd_out = 0; rd_smp = 0;
            aw_have = 0; w_have = 0; wr_busy = 0; wr_cm = 0;
            chk("rst_awready", 64'(awready), 64'd0);
            chk("rst_wready",  64'(wready),  64'd0);
            chk("rst_arready", 64'(arready), 64'd0);
            chk("rst_bvalid",  64'(bvalid),  64'd0);
            chk("rst_rvalid",  64'(rvalid),  64'd0);
            chk("rst_bresp",   64'(bresp),   64'd0);
            chk("rst_rresp",   64'(rresp),   64'd0);
            chk("rst_rdata",   rdata,        64'd0);
        end else begin
            e_awr   = armed && !wr_busy && !aw_have;
            e_wr    = armed && !wr_busy && !w_have;
            e_bv    = wr_busy && wr_cm;
            e_arr   = armed && !rd_out;
            e_rv    = rd_out && rd_smp;
            e_rdata = e_rv ? rd_d : 64'd0;
            chk("m_awready", 64'(awready), 64'(e_awr));
            chk("m_wready",  64'(wready),  64'(e_wr));
            chk("m_bvalid",  64'(bvalid),  64'(e_bv));
            chk("m_arready", 64'(arready), 64'(e_arr));
            chk("m_rvalid",  64'(rvalid),  64'(e_rv));
            chk("m_rdata",   rdata,        e_rdata);
            if (e_bv) chk("m_bresp", 64'(bresp), 64'(wr_r));
            if (e_rv) chk("m_rresp", 64'(rresp), 64'(rd_r));
            n_edge++;
            // Read sample is taken before any same-edge write commit.
            if (rd_out && !rd_smp && n_edge == rd_hs + RD_LAT) begin
                rd_smp = 1;
                rd_r   = m_err(rd_a) ? 2'b10 : 2'b00;
                if (m_err(rd_a)) rd_d = 64'd0;
                else if (mm.exists(m_idx(rd_a))) rd_d = mm[m_idx(rd_a)];
                else rd_d = 'x;
            end
            if (e_rv && rready) begin rd_out = 0; rd_smp = 0; end
            if (e_arr && arvalid) begin rd_out = 1; rd_smp = 0; rd_hs = n_edge; rd_a = araddr; end
            if (wr_busy && !wr_cm && n_edge == wr_done + WR_LAT) begin
                wr_cm = 1;
                wr_r  = m_err(wa) ? 2'b10 : 2'b00;
                if (!m_err(wa)) mm[m_idx(wa)] = wd;
            end
            if (e_bv && bready) begin wr_busy = 0; wr_cm = 0; end
            if (e_awr && awvalid) begin aw_have = 1; wa = awaddr; end
            if (e_wr && wvalid) begin w_have = 1; wd = wdata; end
            if (aw_have && w_have && !wr_busy) begin
                wr_busy = 1; wr_cm = 0; wr_done = n_edge; aw_have = 0; w_have = 0;
            end
            armed = 1;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wr(input logic [ADDR_W-1:0] a, input logic [63:0] d, input int lead,
                      output int lat, output logic [1:0] resp);
        bit aw_done, w_done, hs_aw, hs_w;
        aw_done = 0; w_done = 0;
        wvalid = 1'b1; wdata = d;
        if (lead == 0) begin awvalid = 1'b1; awaddr = a; end
        for (int k = 0; k < 60 && !(aw_done && w_done); k++) begin
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            @(posedge clk); #1;
            if (hs_aw) begin aw_done = 1; awvalid = 1'b0; end
            if (hs_w)  begin w_done = 1;  wvalid = 1'b0; end
            if (!aw_done && !awvalid && k + 1 >= lead) begin awvalid = 1'b1; awaddr = a; end
        end
        lat = 0;
        while (!bvalid && lat < 60) begin @(posedge clk); #1; lat++; end
        resp = bresp;
        if (bvalid) begin @(posedge clk); #1; end
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a, input int hold,
                      output logic [63:0] d, output logic [1:0] r, output int lat);
        bit hs;
        hs = 0;
        arvalid = 1'b1; araddr = a;
        for (int k = 0; k < 60 && !hs; k++) begin
            hs = arready;
            @(posedge clk); #1;
        end
        arvalid = 1'b0;
        lat = 0;
        while (!rvalid && lat < 60) begin @(posedge clk); #1; lat++; end
        d = rdata; r = rresp;
        for (int j = 0; j < hold; j++) begin
            @(posedge clk); #1;
            chk("bp_rvalid",  64'(rvalid),  64'd1);
            chk("bp_rdata",   rdata,        d);
            chk("bp_arready", 64'(arready), 64'd0);
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        if (hold > 0) chk("bp_arready_after", 64'(arready), 64'd1);
    endtask

    function automatic logic [63:0] pat(input int i);
        return 64'hC0DE_0000_0000_0000 + 64'(i) * 64'h0000_0001_0000_0101;
    endfunction

    initial begin : stim
        int lat, lat2;
        logic [1:0] resp, resp2;
        logic [63:0] d, d2;

        // 1: reset
        repeat (3) @(posedge clk);
        #1;
        chk("t1_awready", 64'(awready), 64'd0);
        chk("t1_rvalid",  64'(rvalid),  64'd0);
        chk("t1_rdata",   rdata,        64'd0);
        rst = 1'b0;
        chk("t1_arready_before_edge", 64'(arready), 64'd0);
        @(posedge clk); #1;
        chk("t1_awready_up", 64'(awready), 64'd1);
        chk("t1_wready_up",  64'(wready),  64'd1);
        chk("t1_arready_up", 64'(arready), 64'd1);

        // 2: simple write then read
        wr(17'h10008, 64'hDEAD_BEEF_0123_4567, 0, lat, resp);
        chk("t2_blat",  64'(lat),  64'd4);
        chk("t2_bresp", 64'(resp), 64'd0);
        rd(17'h10008, 0, d, resp, lat);
        chk("t2_rlat",  64'(lat),  64'd4);
        chk("t2_rdata", d,         64'hDEAD_BEEF_0123_4567);
        chk("t2_rresp", 64'(resp), 64'd0);

        // 3: W leads AW by three cycles
        wr(17'h10010, 64'h1, 3, lat, resp);
        chk("t3_blat",  64'(lat),  64'd4);
        chk("t3_bresp", 64'(resp), 64'd0);
        rd(17'h10010, 0, d, resp, lat);
        chk("t3_rdata", d, 64'h1);

        // 4: read backpressure
        rd(17'h10008, 10, d, resp, lat);
        chk("t4_rdata", d, 64'hDEAD_BEEF_0123_4567);

        // 5: errors, with every word prefilled so the scan is meaningful
        for (int i = 0; i < DEPTH; i++) begin
            wr(17'(BASE_I + i * 8), pat(i), 0, lat, resp);
        end
        rd(17'h0FFF8, 0, d, resp, lat);
        chk("t5_lo_rresp", 64'(resp), 64'd2);
        chk("t5_lo_rdata", d,         64'd0);
        rd(17'h10800, 0, d, resp, lat);
        chk("t5_hi_rresp", 64'(resp), 64'd2);
        chk("t5_hi_rdata", d,         64'd0);
        rd(17'h10004, 0, d, resp, lat);
        chk("t5_un_rresp", 64'(resp), 64'd2);
        chk("t5_un_rdata", d,         64'd0);
        wr(17'h10800, 64'h0BAD_0BAD_0BAD_0BAD, 0, lat, resp);
        chk("t5_bresp", 64'(resp), 64'd2);
        for (int i = 0; i < DEPTH; i++) begin
            rd(17'(BASE_I + i * 8), 0, d, resp, lat);
            chk("t5_scan", d, pat(i));
        end

        // 6: same-edge write commit and read sample
        wr(17'h10010, 64'hAAAA_AAAA_AAAA_AAAA, 0, lat, resp);
        fork
            wr(17'h10010, 64'hBBBB_BBBB_BBBB_BBBB, 0, lat, resp);
            rd(17'h10010, 0, d, resp2, lat2);
        join
        chk("t6_old_data", d, 64'hAAAA_AAAA_AAAA_AAAA);
        chk("t6_blat", 64'(lat),  64'd4);
        chk("t6_rlat", 64'(lat2), 64'd4);
        rd(17'h10010, 0, d, resp, lat);
        chk("t6_new_data", d, 64'hBBBB_BBBB_BBBB_BBBB);

        // 6b: reset while the write is waiting to commit
        awvalid = 1'b1; awaddr = 17'h10010;
        wvalid  = 1'b1; wdata  = 64'hCCCC_CCCC_CCCC_CCCC;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int j = 0; j < 8; j++) begin
            @(posedge clk); #1;
            chk("t6_no_bvalid", 64'(bvalid), 64'd0);
        end
        rd(17'h10010, 0, d, resp, lat);
        chk("t6_after_rst", d, 64'hBBBB_BBBB_BBBB_BBBB);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
